// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory and decode-side signal bundle for instruction_fetch_unit.
// master = fetch unit; slave = memory/decode environment.
interface instruction_fetch_unit_if;
   logic [31:0] instruction_addr;
   logic [31:0] instruction_read;
   logic        instruction_ready;
   logic        redirect_valid;
   logic [31:0] redirect_addr;
   logic        fetch_valid;
   logic [31:0] fetch_instr;
   logic [31:0] fetch_pc;
   logic        fetch_ready;

   modport master (
      output instruction_addr,
      input  instruction_read,
      input  instruction_ready,
      input  redirect_valid,
      input  redirect_addr,
      output fetch_valid,
      output fetch_instr,
      output fetch_pc,
      input  fetch_ready
   );

   modport slave (
      input  instruction_addr,
      output instruction_read,
      output instruction_ready,
      output redirect_valid,
      output redirect_addr,
      input  fetch_valid,
      input  fetch_instr,
      input  fetch_pc,
      output fetch_ready
   );
endinterface

// File: rtl/instruction_fetch_unit.sv
// PC-driven instruction fetch with a circular fetch queue and redirect flush.
// Optional IFETCH_ALIGN_CHECK_EN: misaligned redirects raise a sticky fault.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          QUEUE_DEPTH = 2
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            fetch_en,
   output logic                            fetch_fault,
   instruction_fetch_unit_if.master        bus
);
   localparam int               PTR_W   = $clog2(QUEUE_DEPTH);
   localparam int               CNT_W   = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

   typedef enum logic [1:0] {IDLE, FETCH, FAULT} state_t;

   state_t             r_state;
   state_t             w_state_next;
   logic [31:0]        r_pc;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [CNT_W-1:0]   r_count;
   logic [31:0]        r_q_pc    [QUEUE_DEPTH];
   logic [31:0]        r_q_instr [QUEUE_DEPTH];
   logic               w_redirect;
   logic               w_misalign;
   logic               w_push;
   logic               w_pop;
   logic               w_valid;

`ifdef IFETCH_ALIGN_CHECK_EN
   assign w_misalign  = (bus.redirect_addr[1:0] != 2'b00);
   assign fetch_fault = (r_state == FAULT);
`else
   assign w_misalign  = 1'b0;
   assign fetch_fault = 1'b0;
`endif

   // Head outputs come only from queue registers; empty reads as zero.
   assign w_valid              = (r_count != '0) && (r_state != FAULT);
   assign bus.fetch_valid      = w_valid;
   assign bus.fetch_pc         = w_valid ? r_q_pc[r_rd_ptr]    : 32'd0;
   assign bus.fetch_instr      = w_valid ? r_q_instr[r_rd_ptr] : 32'd0;
   assign bus.instruction_addr = r_pc;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_state_next;
   end

   // NOTE: every signal gets a default first so no path through this block infers a latch.
   always_comb begin
      w_state_next = r_state;
      w_redirect   = 1'b0;
      w_pop        = 1'b0;
      w_push       = 1'b0;
      if (r_state != FAULT) begin
         w_redirect = bus.redirect_valid;
         w_pop      = w_valid && bus.fetch_ready && !w_redirect;
         w_push     = (r_state == FETCH) && bus.instruction_ready && !w_redirect &&
                      ((r_count < DEPTH_C) || w_pop);
      end
      case (r_state)
         IDLE:    if (fetch_en)  w_state_next = FETCH;
         FETCH:   if (!fetch_en) w_state_next = IDLE;
         default: w_state_next = FAULT;
      endcase
      if (w_redirect && w_misalign) w_state_next = FAULT;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pc     <= RESET_PC;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (w_redirect) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         if (!w_misalign) r_pc <= {bus.redirect_addr[31:2], 2'b00};
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            r_pc     <= r_pc + 32'd4;
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
         else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
      end
   end

   // NOTE: payload storage is not reset; reads are masked by w_valid, so stale words never escape.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_pc[r_wr_ptr]    <= r_pc;
         r_q_instr[r_wr_ptr] <= bus.instruction_read;
      end
   end
endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

- Initiator side of the instruction-memory interface.
- Drives `instruction_addr` from a program counter and captures `instruction_read` whenever `instruction_ready` is high.
- Buffers fetched words with their PCs in a small queue and hands them to decode over a valid/ready handshake.
- Accepts redirects (branch/jump/trap) that flush the queue.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be 4-byte aligned.
- `QUEUE_DEPTH`, default 2: fetch-queue entries; power of two, ≥2.
- `clk` input 1: the single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low; 0 resets immediately, release is synchronous to `clk`.
- `fetch_en` input 1: 1 = fetch allowed; 0 = pause (queue contents retained).
- `instruction_addr` output 32: byte address to instruction memory; always equals the PC register.
- `instruction_read` input 32: word at `instruction_addr`, combinational from memory.
- `instruction_ready` input 1: `instruction_read` valid this cycle.
- `redirect_valid` input 1: load new PC and flush this cycle.
- `redirect_addr` input 32: redirect target.
- `fetch_valid` output 1: queue head valid.
- `fetch_instr` output 32: queue-head instruction (0 when empty).
- `fetch_pc` output 32: queue-head PC (0 when empty).
- `fetch_ready` input 1: decode accepts the head this cycle.
- `fetch_fault` output 1: sticky misaligned-redirect flag (see Configuration).

## Operation
- States: IDLE, FETCH, FAULT. Reset state is IDLE.
- IDLE→FETCH when `fetch_en`=1. FETCH→IDLE when `fetch_en`=0. FAULT is left only by reset.
- Push:
  - occurs on an edge when state=FETCH, `instruction_ready`=1, no redirect, and (count<QUEUE_DEPTH or a pop occurs on the same edge);
  - writes {PC, `instruction_read`} at tail and sets PC ← PC+4 (mod 2^32, wraps 32'hFFFF_FFFC→0).
- Pop occurs on an edge when `fetch_valid`=1 and `fetch_ready`=1 and no redirect.
- Full queue, no pop: no push; PC and `instruction_addr` hold.
- Simultaneous push+pop is allowed at any count, including full; count is unchanged.
- Redirect (any state except FAULT) has priority over push and pop:
  - queue emptied, PC ← `redirect_addr` with bits [1:0] cleared;
  - the word on `instruction_read` that cycle is discarded and a concurrent pop is void;
  - state is unchanged.
- `instruction_ready`=0 in FETCH: no push, PC holds, `instruction_addr` stable.
- Queue is a circular buffer with read/write pointers of log2(QUEUE_DEPTH) bits plus a count of log2(QUEUE_DEPTH)+1 bits.

## Timing
- Reset values:
  - PC = `instruction_addr` = RESET_PC;
  - count = 0, `fetch_valid`=0, `fetch_instr`=0, `fetch_pc`=0, `fetch_fault`=0;
  - state = IDLE.
- `instruction_addr` is registered; it changes only on the edge after a push or redirect.
- Startup latency: `fetch_en` sampled 1 at edge E0 → FETCH after E0 → first push at E1 (if ready) → `fetch_valid`=1 after E1.
- Redirect latency: redirect at edge Ek → `instruction_addr`=target after Ek → first target entry pushed at Ek+1 → `fetch_valid` after Ek+1.
- Throughput: one instruction per cycle with `instruction_ready` and `fetch_ready` held at 1.
- `fetch_valid`, `fetch_instr`, `fetch_pc` are driven from queue registers only, with no combinational path from `instruction_ready`/`instruction_read`.
- Reset asserted mid-operation: all state returns to reset values immediately; queued entries are lost.

## Configuration
- `IFETCH_ALIGN_CHECK_EN` defined:
  - a redirect with `redirect_addr[1:0]`≠0 sets `fetch_fault`=1 on that edge, flushes the queue, leaves PC unchanged, and moves to FAULT;
  - in FAULT: no push, pop, or redirect; `fetch_valid`=0.
- Undefined: bits [1:0] are silently cleared, `fetch_fault` is tied 0, and FAULT is unreachable.

## Test plan
- Reset, RESET_PC=0, `fetch_en`=1, ready=1, `fetch_ready`=1, memory words 0x00000013/0x00100093/0x00200113 at 0/4/8 → outputs (pc,instr) = (0,0x00000013),(4,0x00100093),(8,0x00200113) on consecutive cycles from cycle 2.
- `fetch_ready`=0 for 5 cycles, QUEUE_DEPTH=2 → count stops at 2, `instruction_addr` holds 8; releasing `fetch_ready` delivers pc 0, then 4, then 8 with no loss or duplication.
- `instruction_ready` toggling 1,0,1,0 → PC advances only on ready cycles; `instruction_addr` is stable while ready=0.
- Queue holding pcs 0,4, redirect_addr=0x40 with `fetch_ready`=1 → queue emptied, pop void, `instruction_addr`=0x40 next cycle, next output pc=0x40.
- PC=32'hFFFF_FFFC, push → `instruction_addr` wraps to 0.
- With `IFETCH_ALIGN_CHECK_EN`, redirect to 0x42 → `fetch_fault`=1, `fetch_valid`=0 permanently until reset. Without the macro, the same stimulus fetches from 0x40 and `fetch_fault` stays 0.
